// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register. Captures the decoded control bundle and
//            operands each cycle for the execute stage, detects load-use
//            hazards (one-cycle bubble plus upstream stall), applies
//            branch/jump flushes and counts inserted bubbles (saturating).
// Ports    : clk, reset (async, active-high)
//            flush_i                  - discard the instruction currently in ID
//            OP_i, control bundle, PC, operands, immediate, register
//            addresses, funct fields  - from decoder / register file
//            *_o                      - registered copies for EX
//            Stall_o                  - combinational; hold PC and IF/ID
//            Bubble_Count_o           - bubbles inserted since reset
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic [6:0]            OP_i,
  input  logic                  Branch_i,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_to_Reg_i,
  input  logic                  Mem_Write_i,
  input  logic                  ALU_Src_i,
  input  logic                  Reg_Write_i,
  input  logic [2:0]            ALU_Op_i,
  input  logic [DATA_WIDTH-1:0] PC_i,
  input  logic [DATA_WIDTH-1:0] Read_Data_1_i,
  input  logic [DATA_WIDTH-1:0] Read_Data_2_i,
  input  logic [DATA_WIDTH-1:0] Immediate_i,
  input  logic [4:0]            Rs1_i,
  input  logic [4:0]            Rs2_i,
  input  logic [4:0]            Rd_i,
  input  logic [2:0]            Funct3_i,
  input  logic                  Funct7b5_i,
  output logic                  Branch_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_to_Reg_o,
  output logic                  Mem_Write_o,
  output logic                  ALU_Src_o,
  output logic                  Reg_Write_o,
  output logic [2:0]            ALU_Op_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic [DATA_WIDTH-1:0] Immediate_o,
  output logic [4:0]            Rs1_o,
  output logic [4:0]            Rs2_o,
  output logic [4:0]            Rd_o,
  output logic [2:0]            Funct3_o,
  output logic                  Funct7b5_o,
  output logic                  Stall_o,
  output logic [CNT_WIDTH-1:0]  Bubble_Count_o
);

  localparam logic [6:0] c_OP_LUI    = 7'h37;
  localparam logic [6:0] c_OP_JAL    = 7'h6F;
  localparam logic [6:0] c_OP_RTYPE  = 7'h33;
  localparam logic [6:0] c_OP_STORE  = 7'h23;
  localparam logic [6:0] c_OP_BRANCH = 7'h63;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_hazard;
  logic w_bubble;

  // LUI and JAL carry immediate bits in the rs1 field, so it must not match.
  assign w_rs1_used = (OP_i != c_OP_LUI) && (OP_i != c_OP_JAL);
  assign w_rs2_used = (OP_i == c_OP_RTYPE) || (OP_i == c_OP_STORE) ||
                      (OP_i == c_OP_BRANCH);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign w_hazard = Mem_Read_o && (Rd_o != 5'd0) &&
                    ((w_rs1_used && (Rs1_i == Rd_o)) ||
                     (w_rs2_used && (Rs2_i == Rd_o)));

  // A flush kills the ID instruction anyway, so there is nothing to hold.
  assign Stall_o  = w_hazard && !flush_i;
  assign w_bubble = flush_i || w_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Branch_o       <= 1'b0;
      Mem_Read_o     <= 1'b0;
      Mem_to_Reg_o   <= 1'b0;
      Mem_Write_o    <= 1'b0;
      ALU_Src_o      <= 1'b0;
      Reg_Write_o    <= 1'b0;
      ALU_Op_o       <= 3'd0;
      PC_o           <= '0;
      Read_Data_1_o  <= '0;
      Read_Data_2_o  <= '0;
      Immediate_o    <= '0;
      Rs1_o          <= 5'd0;
      Rs2_o          <= 5'd0;
      Rd_o           <= 5'd0;
      Funct3_o       <= 3'd0;
      Funct7b5_o     <= 1'b0;
      Bubble_Count_o <= '0;
    end else if (w_bubble) begin
      // Bubble: all-zero bundle is a NOP; data fields zeroed for tidiness.
      Branch_o       <= 1'b0;
      Mem_Read_o     <= 1'b0;
      Mem_to_Reg_o   <= 1'b0;
      Mem_Write_o    <= 1'b0;
      ALU_Src_o      <= 1'b0;
      Reg_Write_o    <= 1'b0;
      ALU_Op_o       <= 3'd0;
      PC_o           <= '0;
      Read_Data_1_o  <= '0;
      Read_Data_2_o  <= '0;
      Immediate_o    <= '0;
      Rs1_o          <= 5'd0;
      Rs2_o          <= 5'd0;
      Rd_o           <= 5'd0;
      Funct3_o       <= 3'd0;
      Funct7b5_o     <= 1'b0;
      if (Bubble_Count_o != c_CNT_MAX) begin
        Bubble_Count_o <= Bubble_Count_o + c_CNT_ONE;
      end
    end else begin
      Branch_o       <= Branch_i;
      Mem_Read_o     <= Mem_Read_i;
      Mem_to_Reg_o   <= Mem_to_Reg_i;
      Mem_Write_o    <= Mem_Write_i;
      ALU_Src_o      <= ALU_Src_i;
      Reg_Write_o    <= Reg_Write_i;
      ALU_Op_o       <= ALU_Op_i;
      PC_o           <= PC_i;
      Read_Data_1_o  <= Read_Data_1_i;
      Read_Data_2_o  <= Read_Data_2_i;
      Immediate_o    <= Immediate_i;
      Rs1_o          <= Rs1_i;
      Rs2_o          <= Rs2_i;
      Rd_o           <= Rd_i;
      Funct3_o       <= Funct3_i;
      Funct7b5_o     <= Funct7b5_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: directed vector table,
//            hand-written reset/saturation sequences and a randomized run
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          branch;
    logic          mem_read;
    logic          mem_to_reg;
    logic          mem_write;
    logic          alu_src;
    logic          reg_write;
    logic [2:0]    alu_op;
    logic [DW-1:0] pc;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic          funct7b5;
  } out_t;

  typedef struct packed {
    logic [6:0] op;
    out_t       f;
  } in_t;

  typedef struct {
    logic fl;
    in_t  d;
    logic exp_stall;
    logic exp_bubble;
    int   exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  logic flush;
  in_t  din;
  out_t dout;
  logic stall;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .OP_i(din.op),
    .Branch_i(din.f.branch), .Mem_Read_i(din.f.mem_read),
    .Mem_to_Reg_i(din.f.mem_to_reg), .Mem_Write_i(din.f.mem_write),
    .ALU_Src_i(din.f.alu_src), .Reg_Write_i(din.f.reg_write),
    .ALU_Op_i(din.f.alu_op), .PC_i(din.f.pc),
    .Read_Data_1_i(din.f.rd1), .Read_Data_2_i(din.f.rd2),
    .Immediate_i(din.f.imm), .Rs1_i(din.f.rs1), .Rs2_i(din.f.rs2),
    .Rd_i(din.f.rd), .Funct3_i(din.f.funct3), .Funct7b5_i(din.f.funct7b5),
    .Branch_o(dout.branch), .Mem_Read_o(dout.mem_read),
    .Mem_to_Reg_o(dout.mem_to_reg), .Mem_Write_o(dout.mem_write),
    .ALU_Src_o(dout.alu_src), .Reg_Write_o(dout.reg_write),
    .ALU_Op_o(dout.alu_op), .PC_o(dout.pc),
    .Read_Data_1_o(dout.rd1), .Read_Data_2_o(dout.rd2),
    .Immediate_o(dout.imm), .Rs1_o(dout.rs1), .Rs2_o(dout.rs2),
    .Rd_o(dout.rd), .Funct3_o(dout.funct3), .Funct7b5_o(dout.funct7b5),
    .Stall_o(stall), .Bubble_Count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic in_t ins(input logic [6:0] op, input logic [5:0] ctl,
                              input logic [2:0] aop, input logic [31:0] pc,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [4:0] d,
                              input logic [2:0] f3, input logic f7);
    in_t x;
    x.op = op;
    {x.f.branch, x.f.mem_read, x.f.mem_to_reg, x.f.mem_write, x.f.alu_src, x.f.reg_write} = ctl;
    x.f.alu_op = aop; x.f.pc = pc; x.f.rd1 = r1; x.f.rd2 = r2; x.f.imm = im;
    x.f.rs1 = s1; x.f.rs2 = s2; x.f.rd = d; x.f.funct3 = f3; x.f.funct7b5 = f7;
    return x;
  endfunction

  // Drive one ID-stage instruction between edges, sample Stall_o mid-cycle,
  // then let one rising edge pass and return just after it.
  task automatic step(input logic fl, input in_t d, output logic st);
    @(negedge clk);
    flush = fl;
    din   = d;
    #1;
    st = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    din   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: which source registers an opcode actually reads.
  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h6F});
  endfunction
  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic in_t rand_ins();
    logic [6:0] ops [9];
    in_t x;
    ops = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h17, 7'h67};
    x = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    x.op = ops[$urandom_range(0, 8)];
    x.f.mem_read = (x.op == 7'h03) || ($urandom_range(0, 7) == 0);
    x.f.rs1 = 5'($urandom_range(0, 7));
    x.f.rs2 = 5'($urandom_range(0, 7));
    x.f.rd  = 5'($urandom_range(0, 7));
    return x;
  endfunction

  vec_t tbl[18];
  in_t  ADD, LW5, ADD6, LW0, ADD0, LUI, ADDI, SW, JAL;

  initial begin
    logic st;
    out_t ex;
    int   mcnt;
    in_t  cur;
    logic hold;
    logic fl;
    logic hz;
    logic exp_st;

    reset = 1'b1;
    flush = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 160'(dout), 160'(0));
    chk("reset_count", 160'(cnt), 160'(0));
    chk("reset_stall", 160'(stall), 160'(0));
    reset = 1'b0;

    ADD  = ins(7'h33, 6'b000001, 3'd0, 32'h100, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 3'd0, 1'b0);
    LW5  = ins(7'h03, 6'b011011, 3'd0, 32'h104, 32'h40, 32'h0, 32'h4, 5'd2, 5'd0, 5'd5, 3'd2, 1'b0);
    ADD6 = ins(7'h33, 6'b000001, 3'd0, 32'h108, 32'h55, 32'h77, 32'h0, 5'd5, 5'd7, 5'd6, 3'd0, 1'b0);
    LW0  = ins(7'h03, 6'b011011, 3'd0, 32'h10c, 32'h9, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, 3'd2, 1'b0);
    ADD0 = ins(7'h33, 6'b000001, 3'd0, 32'h110, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 3'd0, 1'b1);
    LUI  = ins(7'h37, 6'b000011, 3'd1, 32'h114, 32'h0, 32'h0, 32'h12345000, 5'd5, 5'd0, 5'd8, 3'd0, 1'b0);
    ADDI = ins(7'h13, 6'b000011, 3'd2, 32'h118, 32'h3, 32'h0, 32'h1, 5'd1, 5'd5, 5'd9, 3'd0, 1'b0);
    SW   = ins(7'h23, 6'b000110, 3'd0, 32'h11c, 32'h1000, 32'hAB, 32'h10, 5'd1, 5'd5, 5'd0, 3'd2, 1'b0);
    JAL  = ins(7'h6F, 6'b000001, 3'd3, 32'h120, 32'h0, 32'h0, 32'h8, 5'd5, 5'd0, 5'd1, 3'd0, 1'b0);

    tbl = '{
      '{1'b0, ADD,  1'b0, 1'b0, 0},   // plain R-type pass-through
      '{1'b0, LW5,  1'b0, 1'b0, 0},
      '{1'b0, ADD6, 1'b1, 1'b1, 1},   // rs1 depends on load in EX
      '{1'b0, ADD6, 1'b0, 1'b0, 1},   // re-presented after bubble
      '{1'b0, LW0,  1'b0, 1'b0, 1},
      '{1'b0, ADD0, 1'b0, 1'b0, 1},   // load to x0 never stalls
      '{1'b0, LW5,  1'b0, 1'b0, 1},
      '{1'b0, LUI,  1'b0, 1'b0, 1},   // LUI rs1 field ignored
      '{1'b0, LW5,  1'b0, 1'b0, 1},
      '{1'b0, ADDI, 1'b0, 1'b0, 1},   // I-type rs2 field ignored
      '{1'b0, LW5,  1'b0, 1'b0, 1},
      '{1'b1, ADD6, 1'b0, 1'b1, 2},   // flush beats hazard
      '{1'b0, ADD6, 1'b0, 1'b0, 2},
      '{1'b0, LW5,  1'b0, 1'b0, 2},
      '{1'b0, SW,   1'b1, 1'b1, 3},   // store rs2 depends on load
      '{1'b0, SW,   1'b0, 1'b0, 3},
      '{1'b0, LW5,  1'b0, 1'b0, 3},
      '{1'b0, JAL,  1'b0, 1'b0, 3}    // JAL rs1 field ignored
    };

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].fl, tbl[i].d, st);
      chk($sformatf("vec%0d_stall", i), 160'(st), 160'(tbl[i].exp_stall));
      chk($sformatf("vec%0d_out", i), 160'(dout),
          tbl[i].exp_bubble ? 160'(0) : 160'(tbl[i].d.f));
      chk($sformatf("vec%0d_cnt", i), 160'(cnt), 160'(tbl[i].exp_cnt));
    end

    // Reset asserted in the middle of a stall cycle.
    step(1'b0, LW5, st);
    @(negedge clk);
    din = ADD6;
    #1;
    chk("midreset_pre_stall", 160'(stall), 160'(1));
    reset = 1'b1;
    #1;
    chk("midreset_outputs", 160'(dout), 160'(0));
    chk("midreset_count", 160'(cnt), 160'(0));
    chk("midreset_stall", 160'(stall), 160'(0));
    #1;
    reset = 1'b0;

    // Saturation: 20 consecutive flushes on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ADD, st);
      chk($sformatf("sat%0d_cnt", i), 160'(cnt), 160'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
    end

    // Randomized run against the instruction-level model.
    do_reset();
    ex   = '0;
    mcnt = 0;
    hold = 1'b0;
    cur  = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) cur = rand_ins();
      fl = ($urandom_range(0, 9) == 0);
      hz = ex.mem_read && (ex.rd != 5'd0) &&
           ((reads_rs1(cur.op) && cur.f.rs1 == ex.rd) ||
            (reads_rs2(cur.op) && cur.f.rs2 == ex.rd));
      exp_st = hz && !fl;
      step(fl, cur, st);
      if (fl || hz) begin
        ex   = '0;
        mcnt = (mcnt < CNT_MAX) ? mcnt + 1 : CNT_MAX;
      end else begin
        ex = cur.f;
      end
      hold = exp_st;
      chk($sformatf("rnd%0d_stall", n), 160'(st), 160'(exp_st));
      chk($sformatf("rnd%0d_out", n), 160'(dout), 160'(ex));
      chk($sformatf("rnd%0d_cnt", n), 160'(cnt), 160'(mcnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
